// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg: write-bus layout and arbiter state encodings shared by the
// RF write-port arbiter and its LU result buffer.
package rf_wport_arbiter_pkg;

    localparam int WB_BUS_W   = 38;
    localparam int WB_WE      = 37;
    localparam int WB_ADDR_HI = 36;
    localparam int WB_ADDR_LO = 32;
    localparam int WB_DATA_HI = 31;
    localparam int LU_BUS_W   = 5 + 32 + 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PEND  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rf_wport_arbiter_buf.sv
// rf_wport_arbiter_buf: one-entry {dest,data,pc} holding register for a parked LU result.
// Load wins over clear so a drain and a refill can share the same edge.
module rf_wport_arbiter_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        clear,
    input  logic [4:0]  load_dest,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [4:0]  dest,
    output logic [31:0] data,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            dest  <= '0;
            data  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dest  <= load_dest;
            data  <= load_data;
            pc    <= load_pc;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the register-file write port between WB (priority) and a buffered LU result.
// Define RF_ARB_ANTISTARVE_EN to add the FORCE state that holds WB for one cycle to drain a starved buffer.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WB_BUS_W-1:0] ws_wb_bus,
    input  logic [31:0]         ws_pc,
    output logic                ws_hold,
    input  logic                lu_valid,
    output logic                lu_ready,
    input  logic [4:0]          lu_dest,
    input  logic [31:0]         lu_data,
    input  logic [31:0]         lu_pc,
    output logic [WB_BUS_W-1:0] rf_wb_bus,
    output logic [4:0]          lu_pend_dest,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || (1 << CNT_W) <= STARVE_LIMIT) begin : g_bad_cfg
        $error("rf_wport_arbiter: STARVE_LIMIT must be 1..15 and below 2**CNT_W");
    end

    arb_state_e  state, state_nxt;
    logic        ws_we, ws_fire, buf_grant, buf_load, buf_clear, buf_valid_nxt, rf_we;
    logic [4:0]  ws_addr, w_addr;
    logic [31:0] ws_data, w_data, w_pc;
    logic        buf_valid;
    logic [4:0]  buf_dest;
    logic [31:0] buf_data, buf_pc;

    assign ws_we   = ws_wb_bus[WB_WE];
    assign ws_addr = ws_wb_bus[WB_ADDR_HI:WB_ADDR_LO];
    assign ws_data = ws_wb_bus[WB_DATA_HI:0];

    assign buf_grant = buf_valid & (~ws_we | state == ARB_FORCE);
    assign ws_fire   = ws_we & ~buf_grant;
    assign lu_ready  = ~buf_valid | buf_grant;
    // r0 results complete the handshake but never occupy the buffer
    assign buf_load  = lu_valid & lu_ready & (lu_dest != 5'd0);
    // A younger WB write to the same register makes the parked result dead
    assign buf_clear = buf_grant | (ws_fire & buf_valid & ws_addr == buf_dest);
    assign buf_valid_nxt = buf_load | (buf_valid & ~buf_clear);

    rf_wport_arbiter_buf u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_dest (lu_dest),
        .load_data (lu_data),
        .load_pc   (lu_pc),
        .valid     (buf_valid),
        .dest      (buf_dest),
        .data      (buf_data),
        .pc        (buf_pc)
    );

    assign w_addr = buf_grant ? buf_dest : ws_addr;
    assign w_data = buf_grant ? buf_data : ws_data;
    assign w_pc   = buf_grant ? buf_pc   : ws_pc;
    assign rf_we  = (buf_grant | ws_fire) & (w_addr != 5'd0);

    assign rf_wb_bus         = {rf_we, rf_we ? w_addr : 5'd0, rf_we ? w_data : 32'd0};
    assign lu_pend_dest      = buf_valid ? buf_dest : 5'd0;
    assign debug_wb_pc       = rf_we ? w_pc : 32'd0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_we ? w_addr : 5'd0;
    assign debug_wb_rf_wdata = rf_we ? w_data : 32'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ARB_IDLE;
        else         state <= state_nxt;
    end

`ifdef RF_ARB_ANTISTARVE_EN
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wait_cnt <= '0;
        else         wait_cnt <= (state == ARB_PEND && !buf_clear) ? wait_cnt + 1'b1 : '0;
    end

    always_comb begin
        state_nxt = ARB_IDLE;
        if (buf_valid_nxt)
            state_nxt = (state == ARB_PEND && !buf_grant && wait_cnt == CNT_W'(STARVE_LIMIT - 1))
                        ? ARB_FORCE : ARB_PEND;
    end

    assign ws_hold = (state == ARB_FORCE);
`else
    always_comb begin
        state_nxt = ARB_IDLE;
        if (buf_valid_nxt) state_nxt = ARB_PEND;
    end

    assign ws_hold = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed vector table plus hand sequences for starvation, WAW drop and reset.
// Expectations for the starvation case follow RF_ARB_ANTISTARVE_EN.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [37:0] ws_wb_bus;
    logic [31:0] ws_pc;
    logic        ws_hold;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic [31:0] lu_pc;
    logic [37:0] rf_wb_bus;
    logic [4:0]  lu_pend_dest;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_wb_bus         (ws_wb_bus),
        .ws_pc             (ws_pc),
        .ws_hold           (ws_hold),
        .lu_valid          (lu_valid),
        .lu_ready          (lu_ready),
        .lu_dest           (lu_dest),
        .lu_data           (lu_data),
        .lu_pc             (lu_pc),
        .rf_wb_bus         (rf_wb_bus),
        .lu_pend_dest      (lu_pend_dest),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    typedef struct {
        logic        ws_we;
        logic [4:0]  ws_addr;
        logic [31:0] ws_data;
        logic [31:0] ws_pc;
        logic        lu_v;
        logic [4:0]  lu_dest;
        logic [31:0] lu_data;
        logic [31:0] lu_pc;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_pc;
        logic        e_ready;
        logic [4:0]  e_pend;
        logic        e_hold;
    } vec_t;

    function automatic vec_t mk(input logic wwe, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] wp,
                                input logic lv, input logic [4:0] ld, input logic [31:0] ldat, input logic [31:0] lp,
                                input logic ewe, input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] ep,
                                input logic er, input logic [4:0] epd, input logic eh);
        vec_t v;
        v.ws_we = wwe; v.ws_addr = wa; v.ws_data = wd; v.ws_pc = wp;
        v.lu_v = lv; v.lu_dest = ld; v.lu_data = ldat; v.lu_pc = lp;
        v.e_we = ewe; v.e_addr = ea; v.e_data = ed; v.e_pc = ep;
        v.e_ready = er; v.e_pend = epd; v.e_hold = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ws_wb_bus = '0; ws_pc = '0;
        lu_valid = 1'b0; lu_dest = '0; lu_data = '0; lu_pc = '0;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".rf_wb_bus"}, 64'(rf_wb_bus), 64'({v.e_we, v.e_addr, v.e_data}));
        chk({tag, ".dbg_pc"}, 64'(debug_wb_pc), 64'(v.e_pc));
        chk({tag, ".dbg_we"}, 64'(debug_wb_rf_we), 64'({4{v.e_we}}));
        chk({tag, ".dbg_wnum"}, 64'(debug_wb_rf_wnum), 64'(v.e_addr));
        chk({tag, ".dbg_wdata"}, 64'(debug_wb_rf_wdata), 64'(v.e_data));
        chk({tag, ".lu_ready"}, 64'(lu_ready), 64'(v.e_ready));
        chk({tag, ".pend_dest"}, 64'(lu_pend_dest), 64'(v.e_pend));
        chk({tag, ".ws_hold"}, 64'(ws_hold), 64'(v.e_hold));
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle, then take the edge.
    task automatic step(input string tag, input vec_t v);
        ws_wb_bus = {v.ws_we, v.ws_addr, v.ws_data};
        ws_pc = v.ws_pc;
        lu_valid = v.lu_v; lu_dest = v.lu_dest; lu_data = v.lu_data; lu_pc = v.lu_pc;
        @(negedge clk);
        check_outs(tag, v);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[19];
    vec_t idle_none;

    initial begin
        idle_none = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0);
        //            ws: we addr data pc   lu: v dest data pc   exp: we addr data pc  ready pend hold
        tbl[0]  = mk(1,5,32'h1234,32'h100, 0,0,0,0,               1,5,32'h1234,32'h100, 1,0,0);
        tbl[1]  = mk(0,0,0,0,             1,7,32'hAA,32'h200,     0,0,0,0,              1,0,0);
        tbl[2]  = mk(0,0,0,0,             0,0,0,0,                1,7,32'hAA,32'h200,   1,7,0);
        tbl[3]  = idle_none;
        tbl[4]  = mk(0,0,0,0,             1,9,32'h99,32'h300,     0,0,0,0,              1,0,0);
        tbl[5]  = mk(1,9,32'h55,32'h400,  0,0,0,0,                1,9,32'h55,32'h400,   0,9,0);
        tbl[6]  = idle_none;
        tbl[7]  = mk(0,0,0,0,             1,0,32'hDEAD,32'h500,   0,0,0,0,              1,0,0);
        tbl[8]  = idle_none;
        tbl[9]  = mk(1,0,32'h77,32'h580,  0,0,0,0,                0,0,0,0,              1,0,0);
        tbl[10] = mk(0,0,0,0,             1,3,32'h33,32'h600,     0,0,0,0,              1,0,0);
        tbl[11] = mk(0,0,0,0,             1,4,32'h44,32'h610,     1,3,32'h33,32'h600,   1,3,0);
        tbl[12] = mk(0,0,0,0,             0,0,0,0,                1,4,32'h44,32'h610,   1,4,0);
        tbl[13] = idle_none;
        tbl[14] = mk(1,2,32'h22,32'h710,  1,6,32'h66,32'h700,     1,2,32'h22,32'h710,   1,0,0);
        tbl[15] = mk(1,10,32'hA0,32'h720, 1,11,32'hBB,32'h730,    1,10,32'hA0,32'h720,  0,6,0);
        tbl[16] = mk(0,0,0,0,             1,11,32'hBB,32'h730,    1,6,32'h66,32'h700,   1,6,0);
        tbl[17] = mk(0,0,0,0,             0,0,0,0,                1,11,32'hBB,32'h730,  1,11,0);
        tbl[18] = idle_none;

        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", idle_none);
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 19; i++) step($sformatf("vec%0d", i), tbl[i]);

        // Starvation: r7 parked while WB writes r8 every cycle
        step("starve_acc", mk(0,0,0,0, 1,7,32'h77,32'h800, 0,0,0,0, 1,0,0));
`ifdef RF_ARB_ANTISTARVE_EN
        for (int i = 0; i < 8; i++)
            step($sformatf("starve_wb%0d", i), mk(1,8,i,32'h900+i, 0,0,0,0, 1,8,i,32'h900+i, 0,7,0));
        step("starve_force", mk(1,8,8,32'h908, 0,0,0,0, 1,7,32'h77,32'h800, 1,7,1));
        step("starve_resume", mk(1,8,8,32'h908, 0,0,0,0, 1,8,8,32'h908, 1,0,0));
`else
        for (int i = 0; i < 10; i++)
            step($sformatf("starve_wb%0d", i), mk(1,8,i,32'h900+i, 0,0,0,0, 1,8,i,32'h900+i, 0,7,0));
        step("starve_bubble", mk(0,0,0,0, 0,0,0,0, 1,7,32'h77,32'h800, 1,7,0));
`endif
        step("starve_done", idle_none);

        // Mid-PEND reset discards the parked result
        step("rst_acc", mk(0,0,0,0, 1,12,32'hCC,32'hA00, 0,0,0,0, 1,0,0));
        step("rst_pend", mk(1,13,32'hD0,32'hA10, 0,0,0,0, 1,13,32'hD0,32'hA10, 0,12,0));
        drive_idle();
        resetn = 1'b0;
        #2;
        check_outs("rst_mid", idle_none);
        @(posedge clk);
        #1 resetn = 1'b1;
        step("rst_after", idle_none);
        step("rst_after2", idle_none);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
